// File: rtl/bit_dropper_axi_resp_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bit_dropper_axi_pkg
// Brief   : Shared AXI response/burst encodings and FSM state types.
// Revision: 1.0
// ============================================================================
package bit_dropper_axi_pkg;

    typedef logic [1:0] resp_t;
    typedef logic [1:0] burst_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    localparam burst_t BURST_FIXED = 2'b00;
    localparam burst_t BURST_INCR  = 2'b01;
    localparam burst_t BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // WRAP and the reserved encoding both have bit 1 set; neither is served.
    function automatic logic burst_bad(input burst_t b);
        return b[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_dropper_axi_resp_mem_if.sv
`default_nettype none
// ============================================================================
// Module  : bit_dropper_axi_resp_mem_if
// Brief   : AXI4 memory-mapped bus bundle with master and slave views.
// Revision: 1.0
// ============================================================================
interface bit_dropper_axi_resp_mem_if
    import bit_dropper_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [7:0]              S_AXI_AWLEN;
    burst_t                  S_AXI_AWBURST;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WLAST;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    resp_t                   S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [7:0]              S_AXI_ARLEN;
    burst_t                  S_AXI_ARBURST;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    resp_t                   S_AXI_RRESP;
    logic                    S_AXI_RLAST;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface
`default_nettype wire

// File: rtl/bit_dropper_axi_resp_mem_ram.sv
`default_nettype none
// ============================================================================
// Module  : bit_dropper_resp_ram
// Brief   : Register-array RAM, byte-strobed synchronous write, async read.
// Revision: 1.0
// ============================================================================
module bit_dropper_resp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  wire logic                clk,
    input  wire logic                i_we,
    input  wire logic [DATA_W/8-1:0] i_wstrb,
    input  wire logic [ADDR_W-1:0]   i_waddr,
    input  wire logic [DATA_W-1:0]   i_wdata,
    input  wire logic [ADDR_W-1:0]   i_raddr,
    output logic      [DATA_W-1:0]   o_rdata
);
    localparam int c_lanes = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < c_lanes; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/bit_dropper_axi_resp_mem.sv
`default_nettype none
// ============================================================================
// Module  : bit_dropper_axi_resp_mem
// Brief   : AXI4 slave memory terminating the Bit_Dropper M00_AXI port.
//           Define BIT_DROPPER_RESP_STATS_EN to add STAT_* beat counters.
// Revision: 1.0
// ============================================================================
module bit_dropper_axi_resp_mem
    import bit_dropper_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_MEM_DEPTH_LOG2   = 8
) (
    input  wire logic ACLK,
    input  wire logic ARESET,
    bit_dropper_axi_resp_mem_if.slave s_axi
`ifdef BIT_DROPPER_RESP_STATS_EN
    ,
    output logic [31:0] STAT_WR_BEATS,
    output logic [31:0] STAT_RD_BEATS
`endif
);
    localparam int c_idx_w = C_MEM_DEPTH_LOG2;

    // ------------------------------------------------------------------
    // Handshakes; READY outputs stay low until the first edge after reset
    // ------------------------------------------------------------------
    logic      r_live;
    wr_state_t r_wr_state, w_wr_state_nxt;
    rd_state_t r_rd_state, w_rd_state_nxt;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign s_axi.S_AXI_AWREADY = r_live && (r_wr_state == W_IDLE);
    assign s_axi.S_AXI_WREADY  = (r_wr_state == W_DATA);
    assign s_axi.S_AXI_BVALID  = (r_wr_state == W_RESP);
    assign s_axi.S_AXI_ARREADY = r_live && (r_rd_state == R_IDLE);
    assign s_axi.S_AXI_RVALID  = (r_rd_state == R_DATA);

    assign w_aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;
    assign w_b_hs  = s_axi.S_AXI_BVALID  && s_axi.S_AXI_BREADY;
    assign w_ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
    assign w_r_hs  = s_axi.S_AXI_RVALID  && s_axi.S_AXI_RREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_live     <= 1'b0;
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
        end else begin
            r_live     <= 1'b1;
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic [c_idx_w-1:0] r_wr_idx;
    logic [7:0]         r_wr_left;
    burst_t             r_wr_burst;
    logic               r_wr_err;
    logic               w_wr_last_beat;

    assign w_wr_last_beat = (r_wr_left == 8'd0);

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_aw_hs) w_wr_state_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wr_last_beat) w_wr_state_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wr_state_nxt = W_IDLE;
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_wr_idx   <= '0;
            r_wr_left  <= 8'd0;
            r_wr_burst <= BURST_FIXED;
            r_wr_err   <= 1'b0;
        end else if (w_aw_hs) begin
            r_wr_idx   <= s_axi.S_AXI_AWADDR[c_idx_w+1:2];
            r_wr_left  <= s_axi.S_AXI_AWLEN;
            r_wr_burst <= s_axi.S_AXI_AWBURST;
            r_wr_err   <= burst_bad(s_axi.S_AXI_AWBURST);
        end else if (w_w_hs) begin
            if (r_wr_burst == BURST_INCR) r_wr_idx <= r_wr_idx + 1'b1;
            if (!w_wr_last_beat) r_wr_left <= r_wr_left - 8'd1;
            if (s_axi.S_AXI_WLAST != w_wr_last_beat) r_wr_err <= 1'b1;
        end
    end

    assign s_axi.S_AXI_BRESP = (s_axi.S_AXI_BVALID && r_wr_err) ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------
    // Read channel: next beat is fetched on the same edge as the handshake
    // ------------------------------------------------------------------
    logic [c_idx_w-1:0]            r_rd_idx;
    logic [7:0]                    r_rd_left;
    burst_t                        r_rd_burst;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    resp_t                         r_rresp;
    logic                          r_rlast;
    logic [c_idx_w-1:0]            w_rd_idx_nxt;
    logic [c_idx_w-1:0]            w_ram_raddr;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_ram_rdata;
    logic                          w_rd_bad;

    assign w_rd_idx_nxt = (r_rd_burst == BURST_INCR) ? r_rd_idx + 1'b1 : r_rd_idx;
    assign w_ram_raddr  = (r_rd_state == R_IDLE) ? s_axi.S_AXI_ARADDR[c_idx_w+1:2] : w_rd_idx_nxt;
    assign w_rd_bad     = (r_rd_state == R_IDLE) ? burst_bad(s_axi.S_AXI_ARBURST)
                                                 : burst_bad(r_rd_burst);

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_state_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_rd_state_nxt = R_IDLE;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rd_idx   <= '0;
            r_rd_left  <= 8'd0;
            r_rd_burst <= BURST_FIXED;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rlast    <= 1'b0;
        end else if (w_ar_hs) begin
            r_rd_idx   <= s_axi.S_AXI_ARADDR[c_idx_w+1:2];
            r_rd_left  <= s_axi.S_AXI_ARLEN;
            r_rd_burst <= s_axi.S_AXI_ARBURST;
            r_rdata    <= w_rd_bad ? '0 : w_ram_rdata;
            r_rresp    <= w_rd_bad ? RESP_SLVERR : RESP_OKAY;
            r_rlast    <= (s_axi.S_AXI_ARLEN == 8'd0);
        end else if (w_r_hs && !r_rlast) begin
            r_rd_idx   <= w_rd_idx_nxt;
            r_rd_left  <= r_rd_left - 8'd1;
            r_rdata    <= w_rd_bad ? '0 : w_ram_rdata;
            r_rlast    <= (r_rd_left == 8'd1);
        end
    end

    assign s_axi.S_AXI_RDATA = r_rdata;
    assign s_axi.S_AXI_RRESP = r_rresp;
    assign s_axi.S_AXI_RLAST = r_rlast;

    bit_dropper_resp_ram #(
        .ADDR_W (c_idx_w),
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_ram (
        .clk     (ACLK),
        .i_we    (w_w_hs && !burst_bad(r_wr_burst)),
        .i_wstrb (s_axi.S_AXI_WSTRB),
        .i_waddr (r_wr_idx),
        .i_wdata (s_axi.S_AXI_WDATA),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    logic w_unused_addr;
    assign w_unused_addr = &{1'b0,
                             s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:c_idx_w+2], s_axi.S_AXI_AWADDR[1:0],
                             s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:c_idx_w+2], s_axi.S_AXI_ARADDR[1:0]};

`ifdef BIT_DROPPER_RESP_STATS_EN
    logic [31:0] r_stat_wr, r_stat_rd;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_stat_wr <= 32'd0;
            r_stat_rd <= 32'd0;
        end else begin
            if (w_w_hs && !(&r_stat_wr)) r_stat_wr <= r_stat_wr + 32'd1;
            if (w_r_hs && !(&r_stat_rd)) r_stat_rd <= r_stat_rd + 32'd1;
        end
    end

    assign STAT_WR_BEATS = r_stat_wr;
    assign STAT_RD_BEATS = r_stat_rd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bit_dropper_axi_resp_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_bit_dropper_axi_resp_mem
// Brief   : Directed self-checking bench for bit_dropper_axi_resp_mem.
// Revision: 1.0
// ============================================================================
module tb_bit_dropper_axi_resp_mem;
    import bit_dropper_axi_pkg::*;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    bit_dropper_axi_resp_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

`ifdef BIT_DROPPER_RESP_STATS_EN
    logic [31:0] stat_wr, stat_rd;
`endif

    bit_dropper_axi_resp_mem #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .C_MEM_DEPTH_LOG2   (8)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .s_axi  (axi.slave)
`ifdef BIT_DROPPER_RESP_STATS_EN
        ,
        .STAT_WR_BEATS (stat_wr),
        .STAT_RD_BEATS (stat_rd)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rd_data  [16];
    logic [31:0] rd_data2 [16];
    logic [1:0]  rd_resp  [16];
    logic        rd_last  [16];
    logic        rd_last2 [16];
    int          rd_first_cyc, rd_last_cyc;

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        axi.S_AXI_AWADDR = addr; axi.S_AXI_AWLEN = len; axi.S_AXI_AWBURST = burst;
        axi.S_AXI_AWVALID = 1'b1;
        while (axi.S_AXI_AWREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) check_value("aw_timeout", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
        @(negedge ACLK);
        axi.S_AXI_AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        axi.S_AXI_WDATA = data; axi.S_AXI_WSTRB = strb; axi.S_AXI_WLAST = last;
        axi.S_AXI_WVALID = 1'b1;
        while (axi.S_AXI_WREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) check_value("w_timeout", {31'd0, axi.S_AXI_WREADY}, 32'd1);
        @(negedge ACLK);
        axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_WLAST  = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input int bready_delay, output logic [1:0] bresp);
        int n = 0;
        aw_send(addr, len, burst);
        for (int i = 0; i <= int'(len); i++) w_send(wd[i], ws[i], i == int'(len));
        for (int k = 0; k < bready_delay; k++) begin
            check_value($sformatf("bvalid_hold[%0d]", k), {31'd0, axi.S_AXI_BVALID}, 32'd1);
            @(negedge ACLK);
        end
        axi.S_AXI_BREADY = 1'b1;
        while (axi.S_AXI_BVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) check_value("b_timeout", {31'd0, axi.S_AXI_BVALID}, 32'd1);
        bresp = axi.S_AXI_BRESP;
        @(negedge ACLK);
        axi.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic stall);
        axi.S_AXI_RREADY = !stall;
        aw_send_ar(addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            int n = 0;
            while (axi.S_AXI_RVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
            if (n >= 50) check_value("r_timeout", {31'd0, axi.S_AXI_RVALID}, 32'd1);
            if (i == 0) rd_first_cyc = cyc;
            if (i == int'(len)) rd_last_cyc = cyc;
            rd_data[i] = axi.S_AXI_RDATA;
            rd_resp[i] = axi.S_AXI_RRESP;
            rd_last[i] = axi.S_AXI_RLAST;
            if (stall) begin
                @(negedge ACLK);
                axi.S_AXI_RREADY = 1'b1;
            end
            rd_data2[i] = axi.S_AXI_RDATA;
            rd_last2[i] = axi.S_AXI_RLAST;
            @(negedge ACLK);
            if (stall) axi.S_AXI_RREADY = 1'b0;
        end
        axi.S_AXI_RREADY = 1'b0;
    endtask

    task automatic aw_send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n = 0;
        axi.S_AXI_ARADDR = addr; axi.S_AXI_ARLEN = len; axi.S_AXI_ARBURST = burst;
        axi.S_AXI_ARVALID = 1'b1;
        while (axi.S_AXI_ARREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
        if (n >= 50) check_value("ar_timeout", {31'd0, axi.S_AXI_ARREADY}, 32'd1);
        @(negedge ACLK);
        axi.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_awready"}, {31'd0, axi.S_AXI_AWREADY}, 32'd0);
        check_value({tag, "_wready"},  {31'd0, axi.S_AXI_WREADY},  32'd0);
        check_value({tag, "_bvalid"},  {31'd0, axi.S_AXI_BVALID},  32'd0);
        check_value({tag, "_arready"}, {31'd0, axi.S_AXI_ARREADY}, 32'd0);
        check_value({tag, "_rvalid"},  {31'd0, axi.S_AXI_RVALID},  32'd0);
    endtask

    logic [1:0]  bresp;
    logic [31:0] exp8 [8];

    initial begin
        axi.S_AXI_AWADDR = '0; axi.S_AXI_AWLEN = '0; axi.S_AXI_AWBURST = '0; axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_WLAST = 1'b0; axi.S_AXI_WVALID = 1'b0;
        axi.S_AXI_BREADY = 1'b0;
        axi.S_AXI_ARADDR = '0; axi.S_AXI_ARLEN = '0; axi.S_AXI_ARBURST = '0; axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY = 1'b0;

        // Reset state
        repeat (3) @(negedge ACLK);
        check_idle_outputs("rst");
        check_value("rst_rdata", axi.S_AXI_RDATA, 32'd0);
        check_value("rst_rlast", {31'd0, axi.S_AXI_RLAST}, 32'd0);
        check_value("rst_bresp", {30'd0, axi.S_AXI_BRESP}, 32'd0);
        check_value("rst_rresp", {30'd0, axi.S_AXI_RRESP}, 32'd0);
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
        check_value("post_rst_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
        check_value("post_rst_arready", {31'd0, axi.S_AXI_ARREADY}, 32'd1);

        // INCR write 1..8 at 0, read back at one beat per cycle
        for (int i = 0; i < 8; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(32'h0, 8'd7, BURST_INCR, 0, bresp);
        check_value("t1_bresp", {30'd0, bresp}, 32'd0);
        axi_read(32'h0, 8'd7, BURST_INCR, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_value($sformatf("t1_rdata[%0d]", i), rd_data[i], 32'(i + 1));
            check_value($sformatf("t1_rresp[%0d]", i), {30'd0, rd_resp[i]}, 32'd0);
            check_value($sformatf("t1_rlast[%0d]", i), {31'd0, rd_last[i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        check_value("t1_beat_span", 32'(rd_last_cyc - rd_first_cyc), 32'd7);

        // Byte strobes
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        axi_write(32'h10, 8'd0, BURST_INCR, 0, bresp);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        axi_write(32'h10, 8'd0, BURST_INCR, 0, bresp);
        axi_read(32'h10, 8'd0, BURST_INCR, 1'b0);
        check_value("t2_rdata", rd_data[0], 32'hAA22CC44);
        check_value("t2_rlast", {31'd0, rd_last[0]}, 32'd1);

        // FIXED write holds the index
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        axi_write(32'h24, 8'd0, BURST_INCR, 0, bresp);
        wd[0] = 32'd5; wd[1] = 32'd6; wd[2] = 32'd7;
        ws[0] = 4'hF;  ws[1] = 4'hF;  ws[2] = 4'hF;
        axi_write(32'h20, 8'd2, BURST_FIXED, 0, bresp);
        check_value("t3_bresp", {30'd0, bresp}, 32'd0);
        axi_read(32'h20, 8'd1, BURST_INCR, 1'b0);
        check_value("t3_rdata0", rd_data[0], 32'd7);
        check_value("t3_rdata1", rd_data[1], 32'hDEADBEEF);

        // WRAP write suppressed, WRAP read errors
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
        axi_write(32'h30, 8'd3, BURST_INCR, 0, bresp);
        for (int i = 0; i < 4; i++) wd[i] = 32'hFFFFFFFF;
        axi_write(32'h30, 8'd3, BURST_WRAP, 0, bresp);
        check_value("t4_wrap_bresp", {30'd0, bresp}, 32'd2);
        axi_read(32'h30, 8'd3, BURST_INCR, 1'b0);
        for (int i = 0; i < 4; i++)
            check_value($sformatf("t4_keep[%0d]", i), rd_data[i], 32'hC0 + 32'(i));
        axi_read(32'h30, 8'd3, BURST_WRAP, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_value($sformatf("t4_wrap_rdata[%0d]", i), rd_data[i], 32'd0);
            check_value($sformatf("t4_wrap_rresp[%0d]", i), {30'd0, rd_resp[i]}, 32'd2);
            check_value($sformatf("t4_wrap_rlast[%0d]", i), {31'd0, rd_last[i]}, (i == 3) ? 32'd1 : 32'd0);
        end

        // BREADY stall, address wrap, RREADY toggling
        wd[0] = 32'h55; wd[1] = 32'h66; ws[0] = 4'hF; ws[1] = 4'hF;
        axi_write(32'h3FC, 8'd1, BURST_INCR, 5, bresp);
        check_value("t5_bresp", {30'd0, bresp}, 32'd0);
        exp8 = '{32'h66, 32'd2, 32'd3, 32'd4, 32'hAA22CC44, 32'd6, 32'd7, 32'd8};
        axi_read(32'h0, 8'd7, BURST_INCR, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check_value($sformatf("t5_rdata[%0d]", i), rd_data[i], exp8[i]);
            check_value($sformatf("t5_rdata_stall[%0d]", i), rd_data2[i], exp8[i]);
            check_value($sformatf("t5_rlast_stall[%0d]", i), {31'd0, rd_last2[i]}, (i == 7) ? 32'd1 : 32'd0);
        end
        axi_read(32'h3FC, 8'd1, BURST_INCR, 1'b0);
        check_value("t5_wrap_rdata0", rd_data[0], 32'h55);
        check_value("t5_wrap_rdata1", rd_data[1], 32'h66);
        check_value("t5_wrap_rlast1", {31'd0, rd_last[1]}, 32'd1);

        // Reset mid-burst
        for (int i = 0; i < 8; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        axi_write(32'h40, 8'd7, BURST_INCR, 0, bresp);
        aw_send(32'h40, 8'd7, BURST_INCR);
        for (int i = 0; i < 3; i++) w_send(32'hB0 + 32'(i), 4'hF, 1'b0);
        ARESET = 1'b1;
        #1;
        check_idle_outputs("midrst");
`ifdef BIT_DROPPER_RESP_STATS_EN
        check_value("midrst_stat_wr", stat_wr, 32'd0);
`endif
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
        check_value("t6_awready", {31'd0, axi.S_AXI_AWREADY}, 32'd1);
        axi_read(32'h40, 8'd7, BURST_INCR, 1'b0);
        for (int i = 0; i < 8; i++)
            check_value($sformatf("t6_rdata[%0d]", i), rd_data[i],
                        (i < 3) ? 32'hB0 + 32'(i) : 32'hA0 + 32'(i));
`ifdef BIT_DROPPER_RESP_STATS_EN
        check_value("t6_stat_rd", stat_rd, 32'd8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bit_dropper_axi_resp_mem.md
Name: bit_dropper_axi_resp_mem

Overview:
AXI4 memory-mapped responder (slave) that terminates the Bit_Dropper M00_AXI master port in simulation and FPGA loopback builds.
- Accepts single-ID INCR/FIXED bursts into an internal register-array memory.
- Returns the stored data on read bursts.
- Lets the master's write-then-read-compare self-test run without external DDR.

Parameters:
C_S_AXI_DATA_WIDTH, 32, beat width in bits; only 32 supported.
C_S_AXI_ADDR_WIDTH, 32, address width; upper bits beyond memory index ignored.
C_MEM_DEPTH_LOG2, 8, log2 of memory depth in words (256 x 32 bits by default).

Ports:
ACLK  in  1  clock, all logic rising-edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write burst start address.
S_AXI_AWLEN  in  8  write beats minus one.
S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP (unsupported), 11 reserved.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write beat data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WLAST  in  1  last write beat.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read burst start address.
S_AXI_ARLEN  in  8  read beats minus one.
S_AXI_ARBURST  in  2  as AWBURST.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read beat data.
S_AXI_RRESP  out  2  read response.
S_AXI_RLAST  out  1  last read beat.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.

Behaviour:
- Reset: all READY and VALID outputs 0; BRESP, RRESP, RDATA and RLAST 0; both FSMs idle. Memory contents are not reset. ARESET mid-burst aborts immediately; beats already written stay in memory.
- AXSIZE is not ported: every beat is full 32-bit. Word index = addr[C_MEM_DEPTH_LOG2+1:2]. INCR adds 1 per beat and wraps modulo depth. FIXED holds the index.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY = 1; an AW handshake latches address, beat count AWLEN+1 and burst type; AWREADY drops the next cycle.
  - W_DATA: WREADY = 1; each W handshake writes the enabled bytes and advances the index.
  - The burst ends on the (AWLEN+1)th beat. If WLAST disagrees with the beat count on any beat, a sticky error is set.
  - AWBURST = 10 or 11: all beats are accepted but the memory write is suppressed, and the error is set.
  - W_RESP: BVALID = 1 with BRESP = 10 (SLVERR) if the error is set, else 00. BVALID holds until BREADY, then W_IDLE; AWREADY is 1 again the next cycle.
  - Minimum 1 cycle between B handshake and next AW acceptance.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY = 1. On AR handshake, RVALID = 1 the next cycle with RDATA = mem[start] (memory read combinationally, output registered).
  - Each R handshake loads the next beat on the same edge, giving 1 beat/cycle with RREADY held high.
  - RDATA, RRESP and RLAST stay stable while RVALID && !RREADY.
  - RLAST = 1 on beat ARLEN+1. ARLEN = 0 gives a single beat with RLAST = 1.
  - WRAP/reserved burst: RDATA = 0 and RRESP = 10 on every beat, with the full beat count still returned.
  - After the RLAST handshake, return to R_IDLE with ARREADY = 1 the next cycle.
- Read and write channels are independent. A read of a word written on the same edge returns the old value.

Optional Feature:
- Macro BIT_DROPPER_RESP_STATS_EN.
- Defined: adds outputs STAT_WR_BEATS[31:0] and STAT_RD_BEATS[31:0], counting W and R handshakes. They reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package bit_dropper_axi_pkg holds:
  - resp_t localparams RESP_OKAY = 2'b00 and RESP_SLVERR = 2'b10.
  - burst_t localparams BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10.
  - typedefs for the write-FSM and read-FSM state enums.
- One sub-module, bit_dropper_resp_ram: register array with a 4-byte-strobed synchronous write port and a combinational read port.

Test Plan:
- INCR write AWADDR = 0, AWLEN = 7, WDATA 1..8, WSTRB = F, then INCR read of the same range -> BRESP = 00; RDATA 1..8 on consecutive cycles, RLAST only on the 8th beat, RRESP = 00.
- Write 0xAABBCCDD to 0x10, then write 0x11223344 to 0x10 with WSTRB = 0101, then read -> 0xAA22CC44.
- FIXED write to 0x20 of 3 beats (5, 6, 7), then INCR read of 2 beats from 0x20 -> 7, then the unmodified word at 0x24.
- WRAP write of 4 beats -> BRESP = 10 and memory unchanged; WRAP read of 4 beats -> 4 beats of RDATA = 0, RRESP = 10, RLAST on the 4th.
- BREADY held low 5 cycles, and RREADY toggling every other cycle during an 8-beat read -> BVALID held; RDATA/RLAST stable while stalled; no beats lost; address wraps from 0x3FC to 0x000 when reading 2 beats from 0x3FC.
- ARESET pulsed after the 3rd of 8 write beats -> all VALID/READY outputs 0 within the reset; afterwards AWREADY = 1; a read shows the first 3 words written and the rest unchanged.
